ethpipe_rx_multislot: RTL and testbench

//  GMII receive writer: strips preamble/SFD, timestamps each frame, stores it in a ring of 2**SLOT_LOG2 RAM slots.

---
 rtl/ethpipe_rx_multislot.sv | 170 +++++++++++++++++
 tb/tb_ethpipe_rx_multislot.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ethpipe_rx_multislot.sv
// ============================================================================
// Module : ethpipe_rx_multislot
// Brief  : GMII receive writer. Strips preamble/SFD, timestamps each frame and
//          stores it in a ring of host-owned RAM slots with a drop counter.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module ethpipe_rx_multislot #(
    parameter int SLOT_LOG2 = 2,
    parameter int SLOT_AW   = 9
) (
    input  logic                         gmii_rx_clk,
    input  logic                         sys_rst,
    input  logic [63:0]                  global_counter,
    input  logic [7:0]                   gmii_rxd,
    input  logic                         gmii_rx_dv,
    input  logic                         gmii_rx_er,
    input  logic                         rx_enable,
    output logic                         slot_wr_en,
    output logic [SLOT_LOG2+SLOT_AW-1:0] slot_address,
    output logic [31:0]                  slot_data,
    output logic [3:0]                   slot_byte_en,
    output logic                         slot_done,
    output logic [SLOT_LOG2-1:0]         slot_done_idx,
    input  logic                         slot_release,
    input  logic [SLOT_LOG2-1:0]         slot_release_idx,
    output logic [2**SLOT_LOG2-1:0]      slot_busy,
    output logic [SLOT_LOG2-1:0]         rx_wr_ptr,
    output logic [31:0]                  rx_drop_count
);

    localparam int NSLOTS    = 2**SLOT_LOG2;
    localparam int MAX_BYTES = (2**SLOT_AW - 4) * 4;

    localparam logic [2:0] S_WAIT_IDLE = 3'd0;
    localparam logic [2:0] S_IDLE      = 3'd1;
    localparam logic [2:0] S_PREAMBLE  = 3'd2;
    localparam logic [2:0] S_PAYLOAD   = 3'd3;
    localparam logic [2:0] S_COMMIT    = 3'd4;
    localparam logic [2:0] S_DROP      = 3'd5;
    localparam logic [2:0] S_DONE      = 3'd6;

    logic [2:0]        r_state;
    logic [63:0]       r_ts;
    logic [15:0]       r_len;
    logic              r_trunc;
    logic              r_err;
    logic [1:0]        r_hdr_cnt;

    logic [15:0]       w_word;
    logic [31:0]       w_lane_data;
    logic              w_room;
    logic [31:0]       w_hdr_data;
    logic [NSLOTS-1:0] w_busy_next;

    // Payload byte k lands in word 4+k/4, lane k%4; r_len is k before the increment.
    assign w_word      = (r_len >> 2) + 16'd4;
    assign w_lane_data = {24'h0, gmii_rxd} << {r_len[1:0], 3'b000};
    assign w_room      = 32'(r_len) < 32'(MAX_BYTES);

    always_comb begin
        w_hdr_data = 32'h0;
        case (r_hdr_cnt)
            2'd0:    w_hdr_data = r_ts[31:0];
            2'd1:    w_hdr_data = r_ts[63:32];
            2'd2:    w_hdr_data = 32'h0;
            default: w_hdr_data = {r_trunc, r_err, 14'h0, r_len};
        endcase
    end

    // Commit is applied after release so it wins on an index collision.
    always_comb begin
        w_busy_next = slot_busy;
        if (slot_release) w_busy_next[slot_release_idx] = 1'b0;
        if (r_state == S_DONE) w_busy_next[rx_wr_ptr] = 1'b1;
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (sys_rst) begin
            r_state       <= S_WAIT_IDLE;
            r_ts          <= 64'h0;
            r_len         <= 16'h0;
            r_trunc       <= 1'b0;
            r_err         <= 1'b0;
            r_hdr_cnt     <= 2'd0;
            slot_wr_en    <= 1'b0;
            slot_address  <= '0;
            slot_data     <= 32'h0;
            slot_byte_en  <= 4'h0;
            slot_done     <= 1'b0;
            slot_done_idx <= '0;
            slot_busy     <= '0;
            rx_wr_ptr     <= '0;
            rx_drop_count <= 32'h0;
        end else begin
            slot_wr_en <= 1'b0;
            slot_done  <= 1'b0;
            slot_busy  <= w_busy_next;
            case (r_state)
                S_WAIT_IDLE: begin
                    if (!gmii_rx_dv) r_state <= S_IDLE;
                end
                S_IDLE: begin
                    if (gmii_rx_dv) begin
                        if (!rx_enable) begin
                            r_state <= S_WAIT_IDLE;
                        end else if (slot_busy[rx_wr_ptr]) begin
                            r_state <= S_DROP;
                            if (rx_drop_count != 32'hFFFF_FFFF)
                                rx_drop_count <= rx_drop_count + 32'd1;
                        end else begin
                            r_state <= S_PREAMBLE;
                            r_ts    <= global_counter;
                            r_len   <= 16'h0;
                            r_trunc <= 1'b0;
                            r_err   <= 1'b0;
                        end
                    end
                end
                S_PREAMBLE: begin
                    if (!gmii_rx_dv) begin
                        r_state <= S_IDLE;
                    end else begin
                        if (gmii_rx_er) r_err <= 1'b1;
                        if (gmii_rxd == 8'hD5) r_state <= S_PAYLOAD;
                    end
                end
                S_PAYLOAD: begin
                    if (!gmii_rx_dv) begin
                        r_state   <= S_COMMIT;
                        r_hdr_cnt <= 2'd0;
                    end else begin
                        if (gmii_rx_er) r_err <= 1'b1;
                        if (r_len != 16'hFFFF) r_len <= r_len + 16'd1;
                        if (w_room) begin
                            slot_wr_en   <= 1'b1;
                            slot_address <= {rx_wr_ptr, w_word[SLOT_AW-1:0]};
                            slot_data    <= w_lane_data;
                            slot_byte_en <= 4'b0001 << r_len[1:0];
                        end else begin
                            r_trunc <= 1'b1;
                        end
                    end
                end
                S_COMMIT: begin
                    slot_wr_en   <= 1'b1;
                    slot_address <= {rx_wr_ptr, {(SLOT_AW-2){1'b0}}, r_hdr_cnt};
                    slot_data    <= w_hdr_data;
                    slot_byte_en <= 4'hF;
                    r_hdr_cnt    <= r_hdr_cnt + 2'd1;
                    if (r_hdr_cnt == 2'd3) r_state <= S_DONE;
                end
                S_DONE: begin
                    slot_done     <= 1'b1;
                    slot_done_idx <= rx_wr_ptr;
                    rx_wr_ptr     <= rx_wr_ptr + SLOT_LOG2'(1);
                    r_state       <= S_WAIT_IDLE;
                end
                S_DROP: begin
                    if (!gmii_rx_dv) r_state <= S_IDLE;
                end
                default: r_state <= S_WAIT_IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ethpipe_rx_multislot.sv
// ============================================================================
// Module : tb_ethpipe_rx_multislot
// Brief  : Frame-level model and per-cycle checker for ethpipe_rx_multislot
//          (instance a: SLOT_AW=9, instance b: SLOT_AW=5).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_ethpipe_rx_multislot;

    typedef struct {
        int          inst;
        int          addr;
        logic [31:0] data;
        logic [3:0]  be;
    } wr_t;

    typedef struct {
        int inst;
        int idx;
    } done_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] gc = 64'h0;
    logic [7:0]  rxd = 8'h0;
    logic        er = 1'b0;
    logic        en = 1'b1;
    logic        dv_a = 1'b0, dv_b = 1'b0;
    logic        rel_a = 1'b0, rel_b = 1'b0;
    logic [1:0]  rel_idx = 2'd0;

    logic        wr_a, wr_b, done_a, done_b;
    logic [10:0] addr_a;
    logic [6:0]  addr_b;
    logic [31:0] data_a, data_b, drop_a, drop_b;
    logic [3:0]  be_a, be_b, busy_a, busy_b;
    logic [1:0]  didx_a, didx_b, ptr_a, ptr_b;

    always #5 clk = ~clk;

    ethpipe_rx_multislot #(.SLOT_LOG2(2), .SLOT_AW(9)) dut_a (
        .gmii_rx_clk(clk), .sys_rst(rst), .global_counter(gc), .gmii_rxd(rxd),
        .gmii_rx_dv(dv_a), .gmii_rx_er(er), .rx_enable(en), .slot_wr_en(wr_a),
        .slot_address(addr_a), .slot_data(data_a), .slot_byte_en(be_a),
        .slot_done(done_a), .slot_done_idx(didx_a), .slot_release(rel_a),
        .slot_release_idx(rel_idx), .slot_busy(busy_a), .rx_wr_ptr(ptr_a),
        .rx_drop_count(drop_a));

    ethpipe_rx_multislot #(.SLOT_LOG2(2), .SLOT_AW(5)) dut_b (
        .gmii_rx_clk(clk), .sys_rst(rst), .global_counter(gc), .gmii_rxd(rxd),
        .gmii_rx_dv(dv_b), .gmii_rx_er(er), .rx_enable(en), .slot_wr_en(wr_b),
        .slot_address(addr_b), .slot_data(data_b), .slot_byte_en(be_b),
        .slot_done(done_b), .slot_done_idx(didx_b), .slot_release(rel_b),
        .slot_release_idx(rel_idx), .slot_busy(busy_b), .rx_wr_ptr(ptr_b),
        .rx_drop_count(drop_b));

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    wr_t         exp_wr[$];
    done_t       exp_done[$];
    logic [3:0]  mbusy[2];
    int          mptr[2];
    logic [31:0] mdrop[2];

    // Observations recorded by the compare process
    logic [31:0] hdr[2][4];
    int          pay_cnt[2];
    int          last_word[2];

    function automatic int aw(input int i);
        return (i == 0) ? 9 : 5;
    endfunction

    function automatic int maxb(input int i);
        return ((2**aw(i)) - 4) * 4;
    endfunction

    function automatic logic [7:0] pb(input int k);
        return 8'((k * 13 + 7) & 255);
    endfunction

    // Per-cycle compare of RAM writes and done pulses against the model queues
    always @(negedge clk) begin
        logic        w, d;
        int          a, di, word;
        logic [31:0] dat;
        logic [3:0]  b;
        wr_t         e;
        done_t       ed;
        for (int i = 0; i < 2; i++) begin
            w   = (i == 0) ? wr_a : wr_b;
            a   = (i == 0) ? int'(addr_a) : int'(addr_b);
            dat = (i == 0) ? data_a : data_b;
            b   = (i == 0) ? be_a : be_b;
            d   = (i == 0) ? done_a : done_b;
            di  = (i == 0) ? int'(didx_a) : int'(didx_b);
            if (w) begin
                n_tests++;
                if (exp_wr.size() == 0 || exp_wr[0].inst != i) begin
                    n_fail++;
                    $display("FAIL write_unexpected inst%0d: got addr=%0h data=%h be=%h, required no write", i, a, dat, b);
                end else begin
                    e = exp_wr.pop_front();
                    if (a != e.addr || dat !== e.data || b !== e.be) begin
                        n_fail++;
                        $display("FAIL write inst%0d: got addr=%0h data=%h be=%h, required addr=%0h data=%h be=%h",
                                 i, a, dat, b, e.addr, e.data, e.be);
                    end
                end
                word = a % (2**aw(i));
                if (b == 4'hF && word < 4) hdr[i][word] = dat;
                else begin
                    pay_cnt[i]++;
                    last_word[i] = word;
                end
            end
            if (d) begin
                n_tests++;
                if (exp_done.size() == 0 || exp_done[0].inst != i) begin
                    n_fail++;
                    $display("FAIL done_unexpected inst%0d: got idx=%0d, required no done", i, di);
                end else begin
                    ed = exp_done.pop_front();
                    if (di != ed.idx) begin
                        n_fail++;
                        $display("FAIL done_idx inst%0d: got %0d, required %0d", i, di, ed.idx);
                    end
                end
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drive(input int inst, input logic [7:0] b, input logic v, input logic e);
        rxd = b;
        er  = e;
        if (inst == 0) dv_a = v;
        else dv_b = v;
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            mbusy[i] = 4'h0;
            mptr[i]  = 0;
            mdrop[i] = 32'h0;
        end
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        dv_a = 1'b0;
        dv_b = 1'b0;
        er   = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        idle(3);
    endtask

    task automatic release_slot(input int inst, input int idx);
        rel_idx = 2'(idx);
        if (inst == 0) rel_a = 1'b1;
        else rel_b = 1'b1;
        @(posedge clk);
        #1;
        rel_a = 1'b0;
        rel_b = 1'b0;
        mbusy[inst][idx] = 1'b0;
        idle(2);
    endtask

    // npre counts the 0x55 bytes including the one seen at dv rise
    task automatic send_frame(input int inst, input int npre, input bit sfd, input int n,
                              input int er_at, input logic [63:0] ts, input bit enable,
                              input int rst_at);
        int  p, len, word;
        bit  take, drop, errf;
        p    = mptr[inst];
        take = enable && !mbusy[inst][p];
        drop = enable && mbusy[inst][p];
        errf = 1'b0;
        en   = enable;
        gc   = ts;
        for (int i = 0; i < npre; i++) drive(inst, 8'h55, 1'b1, 1'b0);
        if (sfd) begin
            drive(inst, 8'hD5, 1'b1, 1'b0);
            for (int k = 0; k < n; k++) begin
                if (k == rst_at) begin
                    do_reset();
                    return;
                end
                if (take && k < maxb(inst))
                    exp_wr.push_back('{inst, p * (2**aw(inst)) + 4 + k / 4,
                                       32'(pb(k)) << (8 * (k % 4)), 4'(1 << (k % 4))});
                if (k == er_at) errf = 1'b1;
                drive(inst, pb(k), 1'b1, k == er_at);
            end
        end
        if (inst == 0) dv_a = 1'b0;
        else dv_b = 1'b0;
        er = 1'b0;
        if (take && sfd) begin
            len  = (n > 65535) ? 65535 : n;
            word = p * (2**aw(inst));
            exp_wr.push_back('{inst, word + 0, ts[31:0], 4'hF});
            exp_wr.push_back('{inst, word + 1, ts[63:32], 4'hF});
            exp_wr.push_back('{inst, word + 2, 32'h0, 4'hF});
            exp_wr.push_back('{inst, word + 3, {n > maxb(inst), errf, 14'h0, 16'(len)}, 4'hF});
            exp_done.push_back('{inst, p});
            mbusy[inst][p] = 1'b1;
            mptr[inst]     = (p + 1) % 4;
        end
        if (drop && mdrop[inst] != 32'hFFFF_FFFF) mdrop[inst] = mdrop[inst] + 32'd1;
        idle(10);
        en = 1'b1;
    endtask

    task automatic check_state(input int inst);
        check($sformatf("busy%0d", inst), (inst == 0) ? 64'(busy_a) : 64'(busy_b), 64'(mbusy[inst]));
        check($sformatf("ptr%0d", inst), (inst == 0) ? 64'(ptr_a) : 64'(ptr_b), 64'(mptr[inst]));
        check($sformatf("drops%0d", inst), (inst == 0) ? 64'(drop_a) : 64'(drop_b), 64'(mdrop[inst]));
        check("pending_writes", 64'(exp_wr.size()), 64'd0);
        check("pending_done", 64'(exp_done.size()), 64'd0);
    endtask

    initial begin
        int c0;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            pay_cnt[i]   = 0;
            last_word[i] = 0;
        end
        idle(3);
        check("rst_wr_en", 64'(wr_a), 64'd0);
        check("rst_addr", 64'(addr_a), 64'd0);
        check("rst_data", 64'(data_a), 64'd0);
        check("rst_done", 64'(done_a), 64'd0);
        check_state(0);
        rst = 1'b0;
        idle(3);

        // 64-byte frame, hand-computed header and payload extent
        c0 = pay_cnt[0];
        send_frame(0, 7, 1'b1, 64, -1, 64'h1_0000_0010, 1'b1, -1);
        check("f1_w0", 64'(hdr[0][0]), 64'h0000_0010);
        check("f1_w1", 64'(hdr[0][1]), 64'h1);
        check("f1_w2", 64'(hdr[0][2]), 64'h0);
        check("f1_w3", 64'(hdr[0][3]), 64'h0000_0040);
        check("f1_pay_bytes", 64'(pay_cnt[0] - c0), 64'd64);
        check("f1_last_word", 64'(last_word[0]), 64'd19);
        check_state(0);

        send_frame(0, 7, 1'b1, 0, -1, 64'hDEAD_BEEF_0000_0001, 1'b1, -1);
        check("zero_len_w3", 64'(hdr[0][3]), 64'h0);
        send_frame(0, 3, 1'b1, 5, -1, 64'h2, 1'b1, -1);
        send_frame(0, 7, 1'b1, 60, 30, 64'h3, 1'b1, -1);
        check("err_w3", 64'(hdr[0][3]), 64'h4000_003C);
        check("full_busy", 64'(busy_a), 64'hF);
        check_state(0);

        // ring full: drop, then release slot 0 and reuse it
        send_frame(0, 7, 1'b1, 20, -1, 64'h4, 1'b1, -1);
        check("drop_lit", 64'(drop_a), 64'd1);
        check_state(0);
        release_slot(0, 0);
        check("release_busy", 64'(busy_a), 64'hE);
        send_frame(0, 7, 1'b1, 16, -1, 64'h5, 1'b1, -1);
        check_state(0);

        // aborted preamble, then a frame arriving with rx_enable low
        release_slot(0, 1);
        send_frame(0, 4, 1'b0, 0, -1, 64'h6, 1'b1, -1);
        check("nosfd_ptr", 64'(ptr_a), 64'd1);
        check_state(0);
        send_frame(0, 7, 1'b1, 10, -1, 64'h7, 1'b0, -1);
        check_state(0);
        send_frame(0, 7, 1'b1, 9, -1, 64'h8, 1'b1, -1);
        check_state(0);

        // truncation on the small-slot instance
        c0 = pay_cnt[1];
        send_frame(1, 7, 1'b1, 200, -1, 64'h9_0000_00AB, 1'b1, -1);
        check("trunc_w3", 64'(hdr[1][3]), 64'h8000_00C8);
        check("trunc_last_word", 64'(last_word[1]), 64'd31);
        check("trunc_pay_bytes", 64'(pay_cnt[1] - c0), 64'd112);
        check_state(1);

        // reset mid-payload, then a clean frame
        release_slot(0, 2);
        send_frame(0, 7, 1'b1, 40, -1, 64'hA, 1'b1, 10);
        check_state(0);
        check_state(1);
        send_frame(0, 7, 1'b1, 64, -1, 64'hB, 1'b1, -1);
        check("post_rst_busy", 64'(busy_a), 64'h1);
        check("post_rst_ptr", 64'(ptr_a), 64'd1);
        check_state(0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
